capture_sequencer: RTL and testbench

- Sequences camera capture and frame-buffer writes in the pixel-clock domain.
- Issues start/end pulses to the CCD capture stage.
- Gates the frame-buffer write strobe so only whole frames are written.
- Applies colour/gray/filter mode changes only at frame boundaries and discards settling frames after each change; supports continuous run, single snapshot and freeze.

---
 rtl/capture_sequencer.sv | 232 +++++++++++++++++++++++
 tb/tb_capture_sequencer.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/capture_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : capture_sequencer
//  Purpose  : Pixel-clock-domain sequencer for camera capture. Issues
//             start/end pulses to the CCD capture stage, gates the
//             frame-buffer write strobe so only whole frames are written,
//             applies mode changes only at frame boundaries and discards
//             settling frames after each change. Supports continuous run,
//             single snapshot and freeze.
//  Ports    : iCLK        pixel clock
//             iRST        synchronous reset, active-high
//             iFVAL       registered camera frame-valid
//             iSTART_P    one-cycle run request
//             iSTOP_P     one-cycle stop request
//             iSNAP_P     one-cycle snapshot/freeze request
//             iMODE_REQ   requested mode {gray_sel, filter_state[1:0]}
//             oSTART      one-cycle pulse to capture start
//             oEND        one-cycle pulse to capture end
//             oMODE       applied mode (datapath mux/filter select)
//             oWR_EN      frame-buffer write gate (ANDed with DVAL later)
//             oFRAME_CNT  count of frames fully written (wraps)
//             oBUSY       state is neither IDLE nor HOLD
//             oSTATE      IDLE=0 WAIT_SOF=1 RUN=2 SETTLE=3 SNAP=4 HOLD=5
//  Revision : 1.0  initial release
// ============================================================================
module capture_sequencer #(
   parameter int unsigned SETTLE_FRAMES = 2,
   parameter int          CNT_W         = 24
) (
   input  logic             iCLK,
   input  logic             iRST,
   input  logic             iFVAL,
   input  logic             iSTART_P,
   input  logic             iSTOP_P,
   input  logic             iSNAP_P,
   input  logic [2:0]       iMODE_REQ,
   output logic             oSTART,
   output logic             oEND,
   output logic [2:0]       oMODE,
   output logic             oWR_EN,
   output logic [CNT_W-1:0] oFRAME_CNT,
   output logic             oBUSY,
   output logic [2:0]       oSTATE
);

   // Settle counter must hold SETTLE_FRAMES; keep at least one bit.
   localparam int SET_W = (SETTLE_FRAMES < 1) ? 1 : $clog2(SETTLE_FRAMES + 1);

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_WAIT_SOF = 3'd1,
      ST_RUN      = 3'd2,
      ST_SETTLE   = 3'd3,
      ST_SNAP     = 3'd4,
      ST_HOLD     = 3'd5
   } state_t;

   state_t             state_q,      state_d;
   logic               fval_d_q;
   logic               snap_flag_q,  snap_flag_d;
   logic               stop_pend_q,  stop_pend_d;
   logic               frz_pend_q,   frz_pend_d;
   logic [SET_W-1:0]   settle_cnt_q, settle_cnt_d;
   logic [2:0]         mode_q,       mode_d;
   logic [CNT_W-1:0]   frame_cnt_q,  frame_cnt_d;
   logic               start_q,      start_d;
   logic               end_q,        end_d;
   logic               wr_en_q,      wr_en_d;

   logic               sof;
   logic               eof;
   logic               stop_req;
   logic               frz_req;
   logic               mode_chg;

   // fval_d resets high so a frame already active at reset release
   // does not look like a start of frame.
   assign sof = iFVAL & ~fval_d_q;
   assign eof = ~iFVAL & fval_d_q;

   // A request arriving in the eof cycle counts as if it came earlier.
   assign stop_req = stop_pend_q | iSTOP_P;
   assign frz_req  = frz_pend_q  | iSNAP_P;
   assign mode_chg = (iMODE_REQ != mode_q);

   always_comb begin
      state_d      = state_q;
      snap_flag_d  = snap_flag_q;
      stop_pend_d  = stop_pend_q;
      frz_pend_d   = frz_pend_q;
      settle_cnt_d = settle_cnt_q;
      mode_d       = mode_q;
      frame_cnt_d  = frame_cnt_q;
      start_d      = 1'b0;
      end_d        = 1'b0;
      // Write gate trails the state register by one cycle.
      wr_en_d      = (state_q == ST_RUN) || (state_q == ST_SNAP);

      case (state_q)
         ST_IDLE: begin
            if (iSTART_P) begin
               state_d     = ST_WAIT_SOF;
               snap_flag_d = 1'b0;
               start_d     = 1'b1;
            end else if (iSNAP_P) begin
               state_d     = ST_WAIT_SOF;
               snap_flag_d = 1'b1;
               start_d     = 1'b1;
            end
         end

         ST_WAIT_SOF: begin
            if (iSTOP_P) begin
               state_d = ST_IDLE;
               end_d   = 1'b1;
            end else if (sof) begin
               mode_d  = iMODE_REQ;
               state_d = snap_flag_q ? ST_SNAP : ST_RUN;
            end
         end

         ST_RUN: begin
            stop_pend_d = stop_req;
            frz_pend_d  = frz_req;
            if (eof) begin
               frame_cnt_d = frame_cnt_q + CNT_W'(1);
               if (stop_req) begin
                  state_d     = ST_IDLE;
                  end_d       = 1'b1;
                  stop_pend_d = 1'b0;
                  frz_pend_d  = 1'b0;
               end else if (frz_req) begin
                  state_d     = ST_HOLD;
                  end_d       = 1'b1;
                  stop_pend_d = 1'b0;
                  frz_pend_d  = 1'b0;
               end else if (mode_chg) begin
                  mode_d = iMODE_REQ;
                  if (SETTLE_FRAMES > 0) begin
                     settle_cnt_d = SET_W'(SETTLE_FRAMES);
                     state_d      = ST_SETTLE;
                  end
               end
            end
         end

         ST_SETTLE: begin
            if (iSTOP_P) begin
               state_d = ST_IDLE;
               end_d   = 1'b1;
            end else if (eof) begin
               if (mode_chg) begin
                  // Another change while settling restarts the discard window.
                  mode_d       = iMODE_REQ;
                  settle_cnt_d = SET_W'(SETTLE_FRAMES);
               end else if (settle_cnt_q <= SET_W'(1)) begin
                  settle_cnt_d = '0;
                  state_d      = ST_RUN;
               end else begin
                  settle_cnt_d = settle_cnt_q - SET_W'(1);
               end
            end
         end

         ST_SNAP: begin
            stop_pend_d = stop_req;
            if (eof) begin
               frame_cnt_d = frame_cnt_q + CNT_W'(1);
               end_d       = 1'b1;
               state_d     = stop_req ? ST_IDLE : ST_HOLD;
               stop_pend_d = 1'b0;
            end
         end

         ST_HOLD: begin
            if (iSTART_P) begin
               state_d     = ST_WAIT_SOF;
               snap_flag_d = 1'b0;
               start_d     = 1'b1;
            end else if (iSNAP_P) begin
               state_d     = ST_WAIT_SOF;
               snap_flag_d = 1'b1;
               start_d     = 1'b1;
            end else if (iSTOP_P) begin
               state_d = ST_IDLE;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge iCLK) begin
      if (iRST) begin
         state_q      <= ST_IDLE;
         fval_d_q     <= 1'b1;
         snap_flag_q  <= 1'b0;
         stop_pend_q  <= 1'b0;
         frz_pend_q   <= 1'b0;
         settle_cnt_q <= '0;
         mode_q       <= '0;
         frame_cnt_q  <= '0;
         start_q      <= 1'b0;
         end_q        <= 1'b0;
         wr_en_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         fval_d_q     <= iFVAL;
         snap_flag_q  <= snap_flag_d;
         stop_pend_q  <= stop_pend_d;
         frz_pend_q   <= frz_pend_d;
         settle_cnt_q <= settle_cnt_d;
         mode_q       <= mode_d;
         frame_cnt_q  <= frame_cnt_d;
         start_q      <= start_d;
         end_q        <= end_d;
         wr_en_q      <= wr_en_d;
      end
   end

   assign oSTART     = start_q;
   assign oEND       = end_q;
   assign oMODE      = mode_q;
   assign oWR_EN     = wr_en_q;
   assign oFRAME_CNT = frame_cnt_q;
   assign oSTATE     = state_q;
   assign oBUSY      = (state_q != ST_IDLE) && (state_q != ST_HOLD);

endmodule
`default_nettype wire

// File: tb/tb_capture_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_capture_sequencer
//  Purpose  : Self-checking bench for capture_sequencer (CNT_W=4,
//             SETTLE_FRAMES=2). Start/end pulse events are checked by a
//             scoreboard monitor; levels are checked directly.
//  Revision : 1.0  initial release
// ============================================================================
module tb_capture_sequencer;

   localparam int CNT_W = 4;

   localparam logic [1:0] K_START = 2'b10;
   localparam logic [1:0] K_END   = 2'b01;

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_WAIT = 3'd1;
   localparam logic [2:0] S_RUN  = 3'd2;
   localparam logic [2:0] S_SETL = 3'd3;
   localparam logic [2:0] S_SNAP = 3'd4;
   localparam logic [2:0] S_HOLD = 3'd5;

   typedef struct packed {
      logic [1:0]       kind;
      logic [2:0]       state;
      logic [CNT_W-1:0] cnt;
      logic [2:0]       mode;
   } ev_t;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             fval = 1'b1;
   logic             start_p = 1'b0;
   logic             stop_p = 1'b0;
   logic             snap_p = 1'b0;
   logic [2:0]       mode_req = 3'd0;
   logic             o_start;
   logic             o_end;
   logic [2:0]       o_mode;
   logic             o_wr_en;
   logic [CNT_W-1:0] o_cnt;
   logic             o_busy;
   logic [2:0]       o_state;

   int checks = 0;
   int errors = 0;
   ev_t sb_q[$];
   ev_t mon_e;

   capture_sequencer #(.SETTLE_FRAMES(2), .CNT_W(CNT_W)) dut (
      .iCLK       (clk),
      .iRST       (rst),
      .iFVAL      (fval),
      .iSTART_P   (start_p),
      .iSTOP_P    (stop_p),
      .iSNAP_P    (snap_p),
      .iMODE_REQ  (mode_req),
      .oSTART     (o_start),
      .oEND       (o_end),
      .oMODE      (o_mode),
      .oWR_EN     (o_wr_en),
      .oFRAME_CNT (o_cnt),
      .oBUSY      (o_busy),
      .oSTATE     (o_state)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic fval_hi(input int n);
      fval = 1'b1;
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic fval_lo(input int n);
      fval = 1'b0;
      for (int i = 0; i < n; i++) tick();
   endtask

   // One-cycle request pulse; {start, stop, snap}. iFVAL level unchanged.
   task automatic pulse(input logic [2:0] req);
      start_p = req[2];
      stop_p  = req[1];
      snap_p  = req[0];
      tick();
      start_p = 1'b0;
      stop_p  = 1'b0;
      snap_p  = 1'b0;
   endtask

   task automatic expect_ev(input logic [1:0] k, input logic [2:0] s,
                            input int c, input logic [2:0] m);
      ev_t e;
      e.kind  = k;
      e.state = s;
      e.cnt   = CNT_W'(c);
      e.mode  = m;
      sb_q.push_back(e);
   endtask

   // Scoreboard monitor: every start/end pulse must match the next expected event.
   always @(negedge clk) begin
      if (o_start || o_end) begin
         if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_unexpected start=%0b end=%0b state=%0d (t=%0t)",
                     o_start, o_end, o_state, $time);
         end else begin
            mon_e = sb_q.pop_front();
            chk("sb_kind",  int'({o_start, o_end}), int'(mon_e.kind));
            chk("sb_state", int'(o_state),          int'(mon_e.state));
            chk("sb_cnt",   int'(o_cnt),            int'(mon_e.cnt));
            chk("sb_mode",  int'(o_mode),           int'(mon_e.mode));
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      // ---- 1: reset with a frame in progress, then start ----
      rst = 1'b1; fval = 1'b1;
      tick(); tick(); tick();
      chk("rst_state", int'(o_state), int'(S_IDLE));
      chk("rst_wr",    int'(o_wr_en), 0);
      chk("rst_mode",  int'(o_mode),  0);
      chk("rst_cnt",   int'(o_cnt),   0);
      chk("rst_busy",  int'(o_busy),  0);
      rst = 1'b0;
      tick();
      expect_ev(K_START, S_WAIT, 0, 3'd0);
      pulse(3'b100);
      fval_hi(5);
      chk("no_sof_after_rst", int'(o_state), int'(S_WAIT));
      chk("wait_busy",        int'(o_busy),  1);
      fval_lo(4);
      fval = 1'b1; tick();
      chk("t1_run",      int'(o_state), int'(S_RUN));
      chk("t1_wr_lag",   int'(o_wr_en), 0);
      tick();
      chk("t1_wr_rise",  int'(o_wr_en), 1);
      fval_hi(6);
      fval_lo(4);
      chk("t1_cnt1",     int'(o_cnt),   1);

      // ---- 2: two more frames, stop in frame 4 ----
      fval_hi(8); fval_lo(4);
      fval_hi(8); fval_lo(4);
      fval_hi(3);
      pulse(3'b010);
      chk("t2_wr_after_stop", int'(o_wr_en), 1);
      chk("t2_still_run",     int'(o_state), int'(S_RUN));
      fval_hi(3);
      expect_ev(K_END, S_IDLE, 4, 3'd0);
      fval_lo(4);
      chk("t2_cnt4",  int'(o_cnt),   4);
      chk("t2_wr0",   int'(o_wr_en), 0);

      // ---- 3: mode change mid-frame, two settle frames ----
      expect_ev(K_START, S_WAIT, 4, 3'd0);
      pulse(3'b100);
      fval_hi(3);
      mode_req = 3'b101;
      fval_hi(3); fval_lo(3);
      chk("t3_settle",  int'(o_state), int'(S_SETL));
      chk("t3_mode",    int'(o_mode),  5);
      chk("t3_cnt5",    int'(o_cnt),   5);
      fval_hi(2);
      chk("t3_wr_off1", int'(o_wr_en), 0);
      fval_hi(4); fval_lo(3);
      chk("t3_still_settle", int'(o_state), int'(S_SETL));
      fval_hi(2);
      chk("t3_wr_off2", int'(o_wr_en), 0);
      fval_hi(4); fval_lo(3);
      chk("t3_back_run", int'(o_state), int'(S_RUN));
      chk("t3_cnt_hold", int'(o_cnt),   5);
      fval_hi(2);
      chk("t3_wr_on",    int'(o_wr_en), 1);
      pulse(3'b010);
      fval_hi(2);
      expect_ev(K_END, S_IDLE, 6, 3'b101);
      fval_lo(3);

      // ---- 4: snapshot from IDLE ----
      mode_req = 3'b010;
      expect_ev(K_START, S_WAIT, 6, 3'b101);
      pulse(3'b001);
      fval_hi(2);
      chk("t4_snap",  int'(o_state), int'(S_SNAP));
      chk("t4_mode",  int'(o_mode),  2);
      chk("t4_wr",    int'(o_wr_en), 1);
      mode_req = 3'b111;
      pulse(3'b001);
      pulse(3'b100);
      fval_hi(2);
      expect_ev(K_END, S_HOLD, 7, 3'b010);
      fval_lo(3);
      chk("t4_hold",  int'(o_state), int'(S_HOLD));
      chk("t4_busy",  int'(o_busy),  0);
      chk("t4_wr0",   int'(o_wr_en), 0);
      fval_hi(4); fval_lo(3);
      chk("t4_cnt_frozen",  int'(o_cnt),  7);
      chk("t4_mode_frozen", int'(o_mode), 2);

      // ---- 5: snap + stop in one RUN frame; start+snap together ----
      expect_ev(K_START, S_WAIT, 7, 3'b010);
      pulse(3'b100);
      fval_hi(2);
      pulse(3'b001);
      pulse(3'b010);
      fval_hi(2);
      expect_ev(K_END, S_IDLE, 8, 3'b111);
      fval_lo(3);
      chk("t5_stop_wins", int'(o_state), int'(S_IDLE));
      expect_ev(K_START, S_WAIT, 8, 3'b111);
      pulse(3'b101);
      fval_hi(2);
      chk("t5_start_prio", int'(o_state), int'(S_RUN));
      fval_hi(2);
      // stop arriving in the eof cycle itself
      expect_ev(K_END, S_IDLE, 9, 3'b111);
      fval = 1'b0;
      pulse(3'b010);
      fval_lo(3);
      chk("t5_eof_stop", int'(o_state), int'(S_IDLE));

      // ---- 6: reset mid-frame, then counter wrap ----
      expect_ev(K_START, S_WAIT, 9, 3'b111);
      pulse(3'b100);
      fval_hi(3);
      chk("t6_wr_pre", int'(o_wr_en), 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("t6_rst_wr",    int'(o_wr_en), 0);
      chk("t6_rst_state", int'(o_state), int'(S_IDLE));
      chk("t6_rst_mode",  int'(o_mode),  0);
      chk("t6_rst_cnt",   int'(o_cnt),   0);
      expect_ev(K_START, S_WAIT, 0, 3'd0);
      pulse(3'b100);
      fval_hi(2);
      chk("t6_partial_ignored", int'(o_state), int'(S_WAIT));
      fval_lo(2);
      for (int f = 0; f < 17; f++) begin
         fval_hi(4);
         fval_lo(2);
      end
      chk("t6_wrap_cnt", int'(o_cnt),   1);
      chk("t6_wrap_run", int'(o_state), int'(S_RUN));
      pulse(3'b010);
      fval_hi(3);
      expect_ev(K_END, S_IDLE, 2, 3'b111);
      fval_lo(3);

      tick(); tick();
      chk("sb_drain", sb_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
